// File: rtl/jk_req_if.sv
// Requester command channel for jk_bank_sched.
// A valid/ready handshake carrying one masked command with a repeat count.
interface jk_req_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
);
  logic             valid;
  logic             ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] mask;
  logic [CNTW-1:0]  cnt;

  modport master (
    output valid, op, mask, cnt,
    input  ready
  );

  modport slave (
    input  valid, op, mask, cnt,
    output ready
  );
endinterface

// File: rtl/jk_bank_sched.sv
// Round-robin command scheduler for a shared bank of jk flip-flops.
// Drives a granted command for cnt+1 cycles, then one idle gap with done.
module jk_bank_sched #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  jk_req_if.slave          req0,
  jk_req_if.slave          req1,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             gnt_id,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [CNTW-1:0]  rem_q, rem_d;

  logic             sel1;
  logic             take;
  logic [1:0]       win_op;
  logic [WIDTH-1:0] win_mask;
  logic [CNTW-1:0]  win_cnt;

  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  assign sel1 = req1.valid & (~req0.valid | ~last_q);
  assign take = (state_q == IDLE)
              & (req0.valid | req1.valid)
              & ~rst;

  assign req0.ready = take & ~sel1;
  assign req1.ready = take & sel1;

  assign win_op   = sel1 ? req1.op   : req0.op;
  assign win_mask = sel1 ? req1.mask : req0.mask;
  assign win_cnt  = sel1 ? req1.cnt  : req0.cnt;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    op_d    = op_q;
    mask_d  = mask_q;
    j_d     = j_q;
    k_d     = k_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          op_d    = win_op;
          mask_d  = win_mask;
          rem_d   = win_cnt;
          gnt_d   = sel1;
          last_d  = sel1;
          j_d     = win_mask & {WIDTH{win_op[1]}};
          k_d     = win_mask & {WIDTH{win_op[0]}};
          busy_d  = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (rem_q == '0) begin
          j_d     = '0;
          k_d     = '0;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          rem_d = rem_q - CNTW'(1);
          j_d   = mask_q & {WIDTH{op_q[1]}};
          k_d   = mask_q & {WIDTH{op_q[0]}};
        end
      end
      GAP: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= '0;
      mask_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      j_q     <= j_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
    end
  end

  assign j      = j_q;
  assign k      = k_q;
  assign busy   = busy_q;
  assign gnt_id = gnt_q;
  assign done   = done_q;

endmodule

// File: tb/tb_jk_bank_sched.sv
// Directed bench for jk_bank_sched driving an 8-bit jk flip-flop bank.
// Expected values are hand-computed constants per step.
module tb_jk_bank_sched;

  logic       clk;
  logic       rst;
  logic [7:0] j;
  logic [7:0] k;
  logic       busy;
  logic       gnt_id;
  logic       done;
  logic [7:0] bq;

  int total = 0;
  int bad   = 0;

  jk_req_if #(.WIDTH(8), .CNTW(4)) r0 ();
  jk_req_if #(.WIDTH(8), .CNTW(4)) r1 ();

  jk_bank_sched #(.WIDTH(8), .CNTW(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (r0),
    .req1   (r1),
    .j      (j),
    .k      (k),
    .busy   (busy),
    .gnt_id (gnt_id),
    .done   (done)
  );

  // The flip-flop bank the scheduler drives.
  always_ff @(posedge clk) begin
    if (rst) bq <= '0;
    else     bq <= (j & ~bq) | (~k & bq);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Present one command, check its ready, take the edge, drop valid.
  task automatic hs(input bit         id,
                    input logic [1:0] op,
                    input logic [7:0] mask,
                    input logic [3:0] cnt);
    if (id) begin
      r1.op = op; r1.mask = mask; r1.cnt = cnt; r1.valid = 1'b1;
    end else begin
      r0.op = op; r0.mask = mask; r0.cnt = cnt; r0.valid = 1'b1;
    end
    #1;
    chk("hs_ready", {r1.ready, r0.ready}, id ? 32'h2 : 32'h1);
    tick();
    r0.valid = 1'b0;
    r1.valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    r0.valid = 0; r0.op = 0; r0.mask = 0; r0.cnt = 0;
    r1.valid = 0; r1.op = 0; r1.mask = 0; r1.cnt = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_jk", {j, k}, 32'h0);
    chk("rst_flags", {busy, done, gnt_id}, 32'h0);
    chk("rst_ready", {r1.ready, r0.ready}, 32'h0);

    // Single set, cnt=0
    hs(0, 2'b10, 8'hFF, 4'd0);
    chk("set_jk", {j, k}, 32'hFF00);
    chk("set_busy", {busy, done, gnt_id}, 32'h4);
    tick();
    chk("set_gap", {j, k, busy, done}, 32'h3);
    chk("set_q", bq, 32'hFF);
    tick();
    chk("set_idle", {busy, done}, 32'h0);

    // Tie break and alternation
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r0.op = 2'b10; r0.mask = 8'h0F; r0.cnt = 0; r0.valid = 1'b1;
    r1.op = 2'b10; r1.mask = 8'hF0; r1.cnt = 0; r1.valid = 1'b1;
    #1;
    chk("tie_rdy0", {r1.ready, r0.ready}, 32'h1);
    tick();
    chk("tie_gnt0", {gnt_id, j}, 32'h00F);
    chk("tie_busy_rdy", {r1.ready, r0.ready}, 32'h0);
    tick();
    chk("tie_done0", done, 32'h1);
    tick();
    chk("tie_rdy1", {r1.ready, r0.ready}, 32'h2);
    tick();
    chk("tie_gnt1", {gnt_id, j}, 32'h1F0);
    tick();
    tick();
    chk("tie_rdy0b", {r1.ready, r0.ready}, 32'h1);
    tick();
    chk("tie_gnt0b", gnt_id, 32'h0);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    tick();
    tick();
    chk("tie_q", bq, 32'hFF);

    // Toggle cnt=2 from 00
    hs(1, 2'b01, 8'hFF, 4'd0);
    tick();
    tick();
    chk("clr_q", bq, 32'h00);
    hs(0, 2'b11, 8'h0F, 4'd2);
    chk("tg2_jk1", {j, k}, 32'h0F0F);
    tick();
    chk("tg2_q1", bq, 32'h0F);
    tick();
    chk("tg2_jk3", {j, k, busy}, 32'h1E1F);
    tick();
    chk("tg2_gap", {j, k, done}, 32'h1);
    chk("tg2_q", bq, 32'h0F);
    tick();

    // Toggle cnt=3 from 00
    hs(1, 2'b01, 8'hFF, 4'd0);
    tick();
    tick();
    hs(0, 2'b11, 8'h0F, 4'd3);
    tick();
    tick();
    tick();
    chk("tg3_last", {j, k}, 32'h0F0F);
    tick();
    chk("tg3_gap", {done, bq}, 32'h100);
    tick();

    // Max burst reset, mask AA, from FF
    hs(1, 2'b10, 8'hFF, 4'd0);
    tick();
    tick();
    hs(0, 2'b01, 8'hAA, 4'd15);
    for (int i = 0; i < 16; i++) begin
      chk("max_jk", {busy, done, j, k}, 32'h200AA);
      tick();
    end
    chk("max_gap", {done, k}, 32'h100);
    chk("max_q", bq, 32'h55);
    tick();

    // Hold for 6 cycles
    hs(1, 2'b00, 8'hFF, 4'd5);
    for (int i = 0; i < 6; i++) begin
      chk("hold_jk", {busy, done, j, k}, 32'h20000);
      tick();
    end
    chk("hold_gap", {busy, done}, 32'h3);
    chk("hold_q", bq, 32'h55);
    tick();
    chk("hold_idle", busy, 32'h0);

    // Reset during a long toggle
    hs(0, 2'b11, 8'hFF, 4'd9);
    tick();
    tick();
    r1.op = 2'b10; r1.mask = 8'h0F; r1.cnt = 0; r1.valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("mrst_rdy", {r1.ready, r0.ready}, 32'h0);
    tick();
    chk("mrst_out", {j, k, busy, done}, 32'h0);
    rst = 1'b0;
    #1;
    chk("mrst_rdy1", {r1.ready, r0.ready}, 32'h2);
    tick();
    r1.valid = 1'b0;
    chk("mrst_gnt", {done, gnt_id, j}, 32'h10F);
    tick();
    tick();
    chk("mrst_q", bq, 32'h0F);

    // Inputs altered while busy
    hs(0, 2'b10, 8'hF0, 4'd3);
    r0.op = 2'b01; r0.mask = 8'hFF; r0.valid = 1'b1;
    r1.op = 2'b11; r1.mask = 8'hFF; r1.cnt = 0; r1.valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("ign_jk", {j, k}, 32'hF000);
      chk("ign_rdy", {r1.ready, r0.ready}, 32'h0);
      tick();
    end
    chk("ign_gap", {done, r1.ready, r0.ready}, 32'h4);
    tick();
    chk("ign_rr", {r1.ready, r0.ready}, 32'h2);
    chk("ign_q", bq, 32'hFF);
    r0.valid = 1'b0;
    r1.valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
